cp0_reg: RTL

CP0_REG -- requirements
Module: cp0_reg

---
 rtl/cp0_reg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cp0_reg.sv
// MIPS coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Handles software writes, exception/eret side effects and a combinational mfc0 read port.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    localparam logic [4:0]  REG_PRID    = 5'd15;
    localparam logic [4:0]  REG_CONFIG  = 5'd16;
    // Software-writable Cause bits: IV, WP, IP[9:8]
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
    logic [31:0] cause_q, cause_d, epc_q, epc_d, prid_q, prid_d, config_q, config_d;
    logic        timer_q, timer_d;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] cause_wr_val;
    logic        exc_valid;
    logic [4:0]  exc_code;

    always_comb begin
        wr_count     = we_i && (waddr_i == REG_COUNT);
        wr_compare   = we_i && (waddr_i == REG_COMPARE);
        wr_status    = we_i && (waddr_i == REG_STATUS);
        wr_cause     = we_i && (waddr_i == REG_CAUSE);
        wr_epc       = we_i && (waddr_i == REG_EPC);
        cause_wr_val = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

        exc_valid = 1'b1;
        exc_code  = 5'd0;
        case (excepttype_i)
            32'h1:   exc_code = 5'd0;
            32'h8:   exc_code = 5'd8;
            32'ha:   exc_code = 5'd10;
            32'hd:   exc_code = 5'd13;
            32'hc:   exc_code = 5'd12;
            default: exc_valid = 1'b0;
        endcase
    end

    always_comb begin
        count_d   = wr_count ? data_i : count_q + 32'd1;
        compare_d = wr_compare ? data_i : compare_q;
        status_d  = wr_status ? data_i : status_q;
        cause_d   = wr_cause ? cause_wr_val : cause_q;
        epc_d     = wr_epc ? data_i : epc_q;
        prid_d    = PRID_VALUE;
        config_d  = CONFIG_VALUE;

        timer_d = timer_q;
        if (wr_compare)
            timer_d = 1'b0;
        else if (compare_q != 32'd0 && count_q == compare_q)
            timer_d = 1'b1;

        cause_d[15:10] = int_i;

        // Exception side effects are applied last so they override a same-cycle write.
        if (exc_valid) begin
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
        end else if (excepttype_i == 32'he) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= 32'h10000000;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            prid_q    <= PRID_VALUE;
            config_q  <= CONFIG_VALUE;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            prid_q    <= prid_d;
            config_q  <= config_d;
            timer_q   <= timer_d;
        end
    end

    // mfc0 read forwards a same-cycle write so the reader sees the post-write value.
    always_comb begin
        case (raddr_i)
            REG_COUNT:   data_o = wr_count ? data_i : count_q;
            REG_COMPARE: data_o = wr_compare ? data_i : compare_q;
            REG_STATUS:  data_o = wr_status ? data_i : status_q;
            REG_CAUSE:   data_o = wr_cause ? cause_wr_val : cause_q;
            REG_EPC:     data_o = wr_epc ? data_i : epc_q;
            REG_PRID:    data_o = prid_q;
            REG_CONFIG:  data_o = config_q;
            default:     data_o = 32'd0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = config_q;
    assign prid_o      = prid_q;
    assign timer_int_o = timer_q;
endmodule
